// File: rtl/branch_squash_arbiter_if.sv
// ----------------------------------------------------------------------------
// branch_squash_arbiter_if
//   Bundles the branch writeback channels, the commit-side exception request,
//   the registered squash pulse, the filtered writeback copies to the ftq and
//   the arbiter's debug view of its FSM.
//
// Handshake: every transfer here is valid-only with no back-pressure. A
//   channel field is meaningful in a cycle only when its *_vld bit is high in
//   that cycle; the receiver must accept it there and then. o_squash_vld is a
//   single-cycle pulse.
//
// Modports
//   master : exeBlock/commit side plus ctrlBlock/ftq consumer (drives i_*,
//            observes o_* and dbg_*)
//   slave  : the arbiter (reads i_*, drives o_* and dbg_*)
// ----------------------------------------------------------------------------
interface branch_squash_arbiter_if #(
    parameter int BRU_NUM   = 2,
    parameter int ROBIDX_W  = 6,
    parameter int FTQIDX_W  = 4,
    parameter int PC_W      = 64,
    parameter int BLOCK_CYC = 4
);
    localparam int RW    = ROBIDX_W + 1;
    localparam int CNT_W = $clog2(BLOCK_CYC + 1);

    // branch writeback inputs, channel i occupies slice [i*W +: W]
    logic [BRU_NUM-1:0]          i_bwb_vld;
    logic [BRU_NUM-1:0]          i_bwb_mispred;
    logic [BRU_NUM*RW-1:0]       i_bwb_robIdx;
    logic [BRU_NUM*FTQIDX_W-1:0] i_bwb_ftqIdx;
    logic [BRU_NUM*PC_W-1:0]     i_bwb_npc;

    // exception squash request
    logic                        i_except_vld;
    logic [RW-1:0]               i_except_robIdx;
    logic [FTQIDX_W-1:0]         i_except_ftqIdx;
    logic [PC_W-1:0]             i_except_npc;

    // squash pulse
    logic                        o_squash_vld;
    logic                        o_squash_cause;
    logic [RW-1:0]               o_squash_robIdx;
    logic [FTQIDX_W-1:0]         o_squash_ftqIdx;
    logic [PC_W-1:0]             o_squash_npc;

    // filtered, registered branch writeback to ftq
    logic [BRU_NUM-1:0]          o_bwb_vld;
    logic [BRU_NUM-1:0]          o_bwb_mispred;
    logic [BRU_NUM*RW-1:0]       o_bwb_robIdx;
    logic [BRU_NUM*FTQIDX_W-1:0] o_bwb_ftqIdx;
    logic [BRU_NUM*PC_W-1:0]     o_bwb_npc;

    // FSM debug view: 0 IDLE, 1 BLOCK
    logic                        dbg_state;
    logic [CNT_W-1:0]            dbg_block_cnt;

    modport master (
        output i_bwb_vld, i_bwb_mispred, i_bwb_robIdx, i_bwb_ftqIdx, i_bwb_npc,
        output i_except_vld, i_except_robIdx, i_except_ftqIdx, i_except_npc,
        input  o_squash_vld, o_squash_cause, o_squash_robIdx, o_squash_ftqIdx, o_squash_npc,
        input  o_bwb_vld, o_bwb_mispred, o_bwb_robIdx, o_bwb_ftqIdx, o_bwb_npc,
        input  dbg_state, dbg_block_cnt
    );

    modport slave (
        input  i_bwb_vld, i_bwb_mispred, i_bwb_robIdx, i_bwb_ftqIdx, i_bwb_npc,
        input  i_except_vld, i_except_robIdx, i_except_ftqIdx, i_except_npc,
        output o_squash_vld, o_squash_cause, o_squash_robIdx, o_squash_ftqIdx, o_squash_npc,
        output o_bwb_vld, o_bwb_mispred, o_bwb_robIdx, o_bwb_ftqIdx, o_bwb_npc,
        output dbg_state, dbg_block_cnt
    );
endinterface

// File: rtl/branch_squash_arbiter.sv
// ----------------------------------------------------------------------------
// branch_squash_arbiter
//   Picks the oldest mispredicting branch across BRU_NUM writeback channels,
//   lets a commit-side exception override it, and issues a registered
//   one-cycle squash pulse. After any squash the arbiter sits in BLOCK for
//   BLOCK_CYC quiet cycles, dropping branch writebacks that are not older than
//   the last squash (or all of them when the last squash was an exception).
//   All outputs are registered: inputs at cycle t appear at t+1.
//
// Ports
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : branch_squash_arbiter_if.slave (writeback/exception inputs,
//          squash pulse, filtered writeback copies, FSM debug view)
// ----------------------------------------------------------------------------
module branch_squash_arbiter #(
    parameter int BRU_NUM   = 2,
    parameter int ROBIDX_W  = 6,
    parameter int FTQIDX_W  = 4,
    parameter int PC_W      = 64,
    parameter int BLOCK_CYC = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    branch_squash_arbiter_if.slave bus
);
    localparam int RW    = ROBIDX_W + 1;
    localparam int CNT_W = $clog2(BLOCK_CYC + 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_BLOCK = 1'b1} state_t;

    // a older than b; the flag bit flips on each wrap of idx, so differing
    // flags mean the larger idx was allocated first.
    function automatic logic older(input logic [RW-1:0] a, input logic [RW-1:0] b);
        if (a[RW-1] == b[RW-1]) return a[RW-2:0] < b[RW-2:0];
        else                    return a[RW-2:0] > b[RW-2:0];
    endfunction

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            block_cnt_q, block_cnt_d;
    logic [RW-1:0]               last_sq_robIdx_q, last_sq_robIdx_d;
    logic                        last_sq_cause_q, last_sq_cause_d;

    logic                        squash_vld_q, squash_vld_d;
    logic                        squash_cause_q, squash_cause_d;
    logic [RW-1:0]               squash_robIdx_q, squash_robIdx_d;
    logic [FTQIDX_W-1:0]         squash_ftqIdx_q, squash_ftqIdx_d;
    logic [PC_W-1:0]             squash_npc_q, squash_npc_d;

    logic [BRU_NUM-1:0]          bwb_vld_q, bwb_vld_d;
    logic [BRU_NUM-1:0]          bwb_mispred_q, bwb_mispred_d;
    logic [BRU_NUM*RW-1:0]       bwb_robIdx_q, bwb_robIdx_d;
    logic [BRU_NUM*FTQIDX_W-1:0] bwb_ftqIdx_q, bwb_ftqIdx_d;
    logic [BRU_NUM*PC_W-1:0]     bwb_npc_q, bwb_npc_d;

    logic [BRU_NUM-1:0]          drop;
    logic                        cand_found;
    logic [RW-1:0]               cand_robIdx;
    logic [FTQIDX_W-1:0]         cand_ftqIdx;
    logic [PC_W-1:0]             cand_npc;

    always_comb begin
        drop        = '0;
        cand_found  = 1'b0;
        cand_robIdx = '0;
        cand_ftqIdx = '0;
        cand_npc    = '0;

        for (int i = 0; i < BRU_NUM; i++) begin
            drop[i] = (state_q == ST_BLOCK) &&
                      (last_sq_cause_q || !older(bus.i_bwb_robIdx[i*RW +: RW], last_sq_robIdx_q));
            // Strictly-older replacement keeps the lowest channel on a tie.
            if (bus.i_bwb_vld[i] && bus.i_bwb_mispred[i] && !drop[i]) begin
                if (!cand_found || older(bus.i_bwb_robIdx[i*RW +: RW], cand_robIdx)) begin
                    cand_found  = 1'b1;
                    cand_robIdx = bus.i_bwb_robIdx[i*RW +: RW];
                    cand_ftqIdx = bus.i_bwb_ftqIdx[i*FTQIDX_W +: FTQIDX_W];
                    cand_npc    = bus.i_bwb_npc[i*PC_W +: PC_W];
                end
            end
        end
    end

    always_comb begin
        squash_vld_d     = 1'b0;
        squash_cause_d   = squash_cause_q;
        squash_robIdx_d  = squash_robIdx_q;
        squash_ftqIdx_d  = squash_ftqIdx_q;
        squash_npc_d     = squash_npc_q;
        state_d          = state_q;
        block_cnt_d      = block_cnt_q;
        last_sq_robIdx_d = last_sq_robIdx_q;
        last_sq_cause_d  = last_sq_cause_q;

        // An exception at commit is the oldest instruction in flight, so it
        // beats any branch regardless of age.
        if (bus.i_except_vld) begin
            squash_vld_d    = 1'b1;
            squash_cause_d  = 1'b1;
            squash_robIdx_d = bus.i_except_robIdx;
            squash_ftqIdx_d = bus.i_except_ftqIdx;
            squash_npc_d    = bus.i_except_npc;
        end else if (cand_found) begin
            squash_vld_d    = 1'b1;
            squash_cause_d  = 1'b0;
            squash_robIdx_d = cand_robIdx;
            squash_ftqIdx_d = cand_ftqIdx;
            squash_npc_d    = cand_npc;
        end

        if (squash_vld_d) begin
            state_d          = ST_BLOCK;
            block_cnt_d      = CNT_W'(BLOCK_CYC);
            last_sq_robIdx_d = squash_robIdx_d;
            last_sq_cause_d  = squash_cause_d;
        end else if (state_q == ST_BLOCK) begin
            if (block_cnt_q == CNT_W'(1)) begin
                state_d     = ST_IDLE;
                block_cnt_d = '0;
            end else begin
                block_cnt_d = block_cnt_q - CNT_W'(1);
            end
        end

        // Writebacks in the exception cycle are all younger than the trap.
        bwb_vld_d     = bus.i_bwb_vld & ~drop & {BRU_NUM{~bus.i_except_vld}};
        bwb_mispred_d = bus.i_bwb_mispred;
        bwb_robIdx_d  = bus.i_bwb_robIdx;
        bwb_ftqIdx_d  = bus.i_bwb_ftqIdx;
        bwb_npc_d     = bus.i_bwb_npc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            block_cnt_q      <= '0;
            last_sq_robIdx_q <= '0;
            last_sq_cause_q  <= 1'b0;
            squash_vld_q     <= 1'b0;
            squash_cause_q   <= 1'b0;
            squash_robIdx_q  <= '0;
            squash_ftqIdx_q  <= '0;
            squash_npc_q     <= '0;
            bwb_vld_q        <= '0;
            bwb_mispred_q    <= '0;
            bwb_robIdx_q     <= '0;
            bwb_ftqIdx_q     <= '0;
            bwb_npc_q        <= '0;
        end else begin
            state_q          <= state_d;
            block_cnt_q      <= block_cnt_d;
            last_sq_robIdx_q <= last_sq_robIdx_d;
            last_sq_cause_q  <= last_sq_cause_d;
            squash_vld_q     <= squash_vld_d;
            squash_cause_q   <= squash_cause_d;
            squash_robIdx_q  <= squash_robIdx_d;
            squash_ftqIdx_q  <= squash_ftqIdx_d;
            squash_npc_q     <= squash_npc_d;
            bwb_vld_q        <= bwb_vld_d;
            bwb_mispred_q    <= bwb_mispred_d;
            bwb_robIdx_q     <= bwb_robIdx_d;
            bwb_ftqIdx_q     <= bwb_ftqIdx_d;
            bwb_npc_q        <= bwb_npc_d;
        end
    end

    assign bus.o_squash_vld    = squash_vld_q;
    assign bus.o_squash_cause  = squash_cause_q;
    assign bus.o_squash_robIdx = squash_robIdx_q;
    assign bus.o_squash_ftqIdx = squash_ftqIdx_q;
    assign bus.o_squash_npc    = squash_npc_q;
    assign bus.o_bwb_vld       = bwb_vld_q;
    assign bus.o_bwb_mispred   = bwb_mispred_q;
    assign bus.o_bwb_robIdx    = bwb_robIdx_q;
    assign bus.o_bwb_ftqIdx    = bwb_ftqIdx_q;
    assign bus.o_bwb_npc       = bwb_npc_q;
    assign bus.dbg_state       = state_q;
    assign bus.dbg_block_cnt   = block_cnt_q;
endmodule

// File: tb/tb_branch_squash_arbiter.sv
// ----------------------------------------------------------------------------
// tb_branch_squash_arbiter
//   Directed bench for branch_squash_arbiter with default parameters
//   (BRU_NUM 2, ROBIDX_W 6, FTQIDX_W 4, PC_W 64, BLOCK_CYC 4).
// ----------------------------------------------------------------------------
module tb_branch_squash_arbiter;
    localparam int BRU_NUM   = 2;
    localparam int ROBIDX_W  = 6;
    localparam int FTQIDX_W  = 4;
    localparam int PC_W      = 64;
    localparam int BLOCK_CYC = 4;
    localparam int RW        = ROBIDX_W + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt  = 0;
    int   check_cnt = 0;

    branch_squash_arbiter_if #(
        .BRU_NUM(BRU_NUM), .ROBIDX_W(ROBIDX_W), .FTQIDX_W(FTQIDX_W),
        .PC_W(PC_W), .BLOCK_CYC(BLOCK_CYC)
    ) bus ();

    branch_squash_arbiter #(
        .BRU_NUM(BRU_NUM), .ROBIDX_W(ROBIDX_W), .FTQIDX_W(FTQIDX_W),
        .PC_W(PC_W), .BLOCK_CYC(BLOCK_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic clear_inputs();
        bus.i_bwb_vld       = '0;
        bus.i_bwb_mispred   = '0;
        bus.i_bwb_robIdx    = '0;
        bus.i_bwb_ftqIdx    = '0;
        bus.i_bwb_npc       = '0;
        bus.i_except_vld    = 1'b0;
        bus.i_except_robIdx = '0;
        bus.i_except_ftqIdx = '0;
        bus.i_except_npc    = '0;
    endtask

    task automatic drive_bwb(input int ch, input logic mis, input logic [RW-1:0] rob,
                             input logic [FTQIDX_W-1:0] ftq, input logic [PC_W-1:0] npc);
        bus.i_bwb_vld[ch]                        = 1'b1;
        bus.i_bwb_mispred[ch]                    = mis;
        bus.i_bwb_robIdx[ch*RW +: RW]            = rob;
        bus.i_bwb_ftqIdx[ch*FTQIDX_W +: FTQIDX_W] = ftq;
        bus.i_bwb_npc[ch*PC_W +: PC_W]           = npc;
    endtask

    // advance one clock; outputs sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // reset state
        check("rst_squash_vld", 64'(bus.o_squash_vld), 64'd0);
        check("rst_squash_rob", 64'(bus.o_squash_robIdx), 64'd0);
        check("rst_squash_npc", bus.o_squash_npc, 64'd0);
        check("rst_bwb_vld", 64'(bus.o_bwb_vld), 64'd0);
        check("rst_state", 64'(bus.dbg_state), 64'd0);
        check("rst_block_cnt", 64'(bus.dbg_block_cnt), 64'd0);

        // 1: single BRU1 mispredict {0,5}
        drive_bwb(1, 1'b1, 7'd5, 4'd3, 64'h8000_1000);
        step();
        check("t1_squash_vld", 64'(bus.o_squash_vld), 64'd1);
        check("t1_cause", 64'(bus.o_squash_cause), 64'd0);
        check("t1_rob", 64'(bus.o_squash_robIdx), 64'd5);
        check("t1_ftq", 64'(bus.o_squash_ftqIdx), 64'd3);
        check("t1_npc", bus.o_squash_npc, 64'h8000_1000);
        check("t1_bwb_vld", 64'(bus.o_bwb_vld), 64'b10);
        check("t1_state", 64'(bus.dbg_state), 64'd1);
        check("t1_block_cnt", 64'(bus.dbg_block_cnt), 64'd4);
        clear_inputs();
        step();
        check("t1_pulse_end", 64'(bus.o_squash_vld), 64'd0);
        check("t1_rob_hold", 64'(bus.o_squash_robIdx), 64'd5);
        check("t1_cnt_dec", 64'(bus.dbg_block_cnt), 64'd3);

        // 3: younger correct writeback dropped, older mispredict squashes
        drive_bwb(0, 1'b0, 7'd9, 4'd1, 64'h9000);
        step();
        check("t3_young_drop", 64'(bus.o_bwb_vld), 64'b00);
        check("t3_no_squash", 64'(bus.o_squash_vld), 64'd0);
        clear_inputs();
        drive_bwb(1, 1'b1, 7'd3, 4'd2, 64'h3000);
        step();
        check("t3_squash_vld", 64'(bus.o_squash_vld), 64'd1);
        check("t3_rob", 64'(bus.o_squash_robIdx), 64'd3);
        check("t3_bwb_vld", 64'(bus.o_bwb_vld), 64'b10);
        check("t3_block_cnt", 64'(bus.dbg_block_cnt), 64'd4);
        clear_inputs();
        for (int k = 0; k < BLOCK_CYC; k++) step();
        check("t3_back_idle", 64'(bus.dbg_state), 64'd0);

        // 2: wrap-aware age, {0,60} older than {1,2}
        drive_bwb(0, 1'b1, 7'b1_000010, 4'd5, 64'h2222);
        drive_bwb(1, 1'b1, 7'd60, 4'd6, 64'h6060);
        step();
        check("t2_squash_vld", 64'(bus.o_squash_vld), 64'd1);
        check("t2_rob", 64'(bus.o_squash_robIdx), 64'd60);
        check("t2_ftq", 64'(bus.o_squash_ftqIdx), 64'd6);
        check("t2_npc", bus.o_squash_npc, 64'h6060);
        check("t2_bwb_vld", 64'(bus.o_bwb_vld), 64'b11);
        check("t2_bwb_rob", 64'(bus.o_bwb_robIdx), 64'({7'd60, 7'b1_000010}));
        clear_inputs();
        for (int k = 0; k < BLOCK_CYC; k++) step();
        check("t2_back_idle", 64'(bus.dbg_state), 64'd0);

        // 5: block window length
        drive_bwb(1, 1'b1, 7'd5, 4'd3, 64'h8000_1000);
        step();
        check("t5_squash_vld", 64'(bus.o_squash_vld), 64'd1);
        clear_inputs();
        for (int k = 0; k < BLOCK_CYC; k++) begin
            drive_bwb(0, 1'b0, 7'd9, 4'd1, 64'h9000);
            step();
            check("t5_drop", 64'(bus.o_bwb_vld), 64'b00);
        end
        check("t5_idle", 64'(bus.dbg_state), 64'd0);
        step();
        check("t5_forward", 64'(bus.o_bwb_vld), 64'b01);
        check("t5_no_squash", 64'(bus.o_squash_vld), 64'd0);
        clear_inputs();

        // 4: exception beats a same-cycle older mispredict
        bus.i_except_vld    = 1'b1;
        bus.i_except_robIdx = 7'd4;
        bus.i_except_ftqIdx = 4'd7;
        bus.i_except_npc    = 64'h100;
        drive_bwb(0, 1'b1, 7'd2, 4'd2, 64'h2000);
        step();
        check("t4_squash_vld", 64'(bus.o_squash_vld), 64'd1);
        check("t4_cause", 64'(bus.o_squash_cause), 64'd1);
        check("t4_rob", 64'(bus.o_squash_robIdx), 64'd4);
        check("t4_npc", bus.o_squash_npc, 64'h100);
        check("t4_bwb_vld", 64'(bus.o_bwb_vld), 64'b00);
        clear_inputs();
        for (int k = 0; k < BLOCK_CYC; k++) begin
            drive_bwb(0, 1'b1, 7'd1, 4'd1, 64'h1000);
            step();
            check("t4_exc_drop", 64'(bus.o_bwb_vld), 64'b00);
            check("t4_exc_nosq", 64'(bus.o_squash_vld), 64'd0);
        end
        step();
        check("t4_after_sq", 64'(bus.o_squash_vld), 64'd1);
        check("t4_after_cause", 64'(bus.o_squash_cause), 64'd0);
        check("t4_after_rob", 64'(bus.o_squash_robIdx), 64'd1);
        check("t4_after_bwb", 64'(bus.o_bwb_vld), 64'b01);
        clear_inputs();

        // 6: reset in BLOCK with an older mispredict pending
        step();
        rst = 1'b1;
        drive_bwb(0, 1'b1, 7'd0, 4'd1, 64'h1000);
        step();
        check("t6_squash_vld", 64'(bus.o_squash_vld), 64'd0);
        check("t6_bwb_vld", 64'(bus.o_bwb_vld), 64'b00);
        check("t6_state", 64'(bus.dbg_state), 64'd0);
        check("t6_block_cnt", 64'(bus.dbg_block_cnt), 64'd0);
        rst = 1'b0;
        clear_inputs();
        drive_bwb(0, 1'b0, 7'd9, 4'd1, 64'h9000);
        step();
        check("t6_forward", 64'(bus.o_bwb_vld), 64'b01);
        check("t6_no_squash", 64'(bus.o_squash_vld), 64'd0);
        clear_inputs();
        step();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
